// File: rtl/jt12_slotreg.sv
// Per-slot register bank and slot sequencer for the FM core.
// Walks CH x OPS operator slots (channel inner, operator outer) on clk_en,
// presents the stored word of the current slot, and commits one pending
// CPU write (optionally broadcast across all channels of one operator)
// when the sequencer reaches the target slot(s).
module jt12_slotreg #(
    parameter int unsigned CH  = 6,
    parameter int unsigned OPS = 4,
    parameter int unsigned W   = 16,
    localparam int unsigned CHW = $clog2(CH),
    localparam int unsigned OPW = $clog2(OPS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           wr,
    input  logic [CHW-1:0] wr_ch,
    input  logic [OPW-1:0] wr_op,
    input  logic           wr_bcast,
    input  logic [W-1:0]   wr_mask,
    input  logic [W-1:0]   wr_data,
    output logic           busy,
    output logic           ovf,
    output logic [CHW-1:0] cur_ch,
    output logic [OPW-1:0] cur_op,
    output logic           zero,
    output logic [W-1:0]   slot_data
);

    localparam int unsigned NSLOT = CH * OPS;
    localparam int unsigned SW    = $clog2(NSLOT);
    localparam int unsigned CHW1  = CHW + 1;
    localparam int unsigned OPW1  = OPW + 1;

    // Flat slot index: operator row major, channel within the row.
    function automatic logic [SW-1:0] slot_idx(input logic [OPW-1:0] op,
                                               input logic [CHW-1:0] ch);
        slot_idx = SW'(op) * SW'(CH) + SW'(ch);
    endfunction

    // Sequencer and output registers
    logic [CHW-1:0] cur_ch_q, cur_ch_d;
    logic [OPW-1:0] cur_op_q, cur_op_d;
    logic           zero_q, zero_d;
    logic [W-1:0]   slot_data_q, slot_data_d;
    logic           busy_q, busy_d;
    logic           ovf_q, ovf_d;

    // Pending request
    logic [CHW-1:0] pend_ch_q, pend_ch_d;
    logic [OPW-1:0] pend_op_q, pend_op_d;
    logic           pend_bcast_q, pend_bcast_d;
    logic [W-1:0]   pend_mask_q, pend_mask_d;
    logic [W-1:0]   pend_data_q, pend_data_d;
    logic [CHW-1:0] bcnt_q, bcnt_d;

    // Storage
    logic [W-1:0]   mem_q [NSLOT];

    // Combinational helpers
    logic [SW-1:0]  cur_slot_c;
    logic [SW-1:0]  nxt_slot_c;
    logic           in_range_c;
    logic           hit_c;
    logic [W-1:0]   merged_c;

    // Range check on the incoming request; channel is don't-care in broadcast
    always_comb begin
        in_range_c = 1'b1;
        if (!wr_bcast && !({1'b0, wr_ch} < CHW1'(CH))) begin
            in_range_c = 1'b0;
        end
        if (!({1'b0, wr_op} < OPW1'(OPS))) begin
            in_range_c = 1'b0;
        end
    end

    // Commit detection and the masked merge for the current slot
    always_comb begin
        cur_slot_c = slot_idx(cur_op_q, cur_ch_q);
        hit_c      = 1'b0;
        if (busy_q && (cur_op_q == pend_op_q)) begin
            hit_c = pend_bcast_q || (cur_ch_q == pend_ch_q);
        end
        merged_c = (mem_q[cur_slot_c] & ~pend_mask_q) | (pend_data_q & pend_mask_q);
    end

    // Next-state for sequencer, handshake and outputs
    always_comb begin
        cur_ch_d     = cur_ch_q;
        cur_op_d     = cur_op_q;
        zero_d       = zero_q;
        slot_data_d  = slot_data_q;
        busy_d       = busy_q;
        ovf_d        = 1'b0;
        pend_ch_d    = pend_ch_q;
        pend_op_d    = pend_op_q;
        pend_bcast_d = pend_bcast_q;
        pend_mask_d  = pend_mask_q;
        pend_data_d  = pend_data_q;
        bcnt_d       = bcnt_q;
        nxt_slot_c   = '0;

        // Slot advance: channel wraps into the next operator row
        if (cur_ch_q == CHW'(CH - 1)) begin
            cur_ch_d = '0;
            if (cur_op_q == OPW'(OPS - 1)) begin
                cur_op_d = '0;
            end else begin
                cur_op_d = cur_op_q + OPW'(1);
            end
        end else begin
            cur_ch_d = cur_ch_q + CHW'(1);
        end
        zero_d     = (cur_ch_d == '0) && (cur_op_d == '0);
        nxt_slot_c = slot_idx(cur_op_d, cur_ch_d);

        // Next slot's word, forwarding a same-edge commit to that slot
        if (hit_c && (nxt_slot_c == cur_slot_c)) begin
            slot_data_d = merged_c;
        end else begin
            slot_data_d = mem_q[nxt_slot_c];
        end

        // Commit side: broadcast finishes after CH channel updates
        if (hit_c) begin
            if (pend_bcast_q) begin
                if (bcnt_q == CHW'(CH - 1)) begin
                    busy_d = 1'b0;
                    bcnt_d = '0;
                end else begin
                    bcnt_d = bcnt_q + CHW'(1);
                end
            end else begin
                busy_d = 1'b0;
            end
        end

        // Request side: a busy bank or a bad target drops the request
        if (wr) begin
            if (busy_q || !in_range_c) begin
                ovf_d = 1'b1;
            end else begin
                busy_d       = 1'b1;
                pend_ch_d    = wr_ch;
                pend_op_d    = wr_op;
                pend_bcast_d = wr_bcast;
                pend_mask_d  = wr_mask;
                pend_data_d  = wr_data;
                bcnt_d       = '0;
            end
        end
    end

    // State registers, advancing only on clk_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch_q     <= '0;
            cur_op_q     <= '0;
            zero_q       <= 1'b1;
            slot_data_q  <= '0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            pend_ch_q    <= '0;
            pend_op_q    <= '0;
            pend_bcast_q <= 1'b0;
            pend_mask_q  <= '0;
            pend_data_q  <= '0;
            bcnt_q       <= '0;
        end else if (clk_en) begin
            cur_ch_q     <= cur_ch_d;
            cur_op_q     <= cur_op_d;
            zero_q       <= zero_d;
            slot_data_q  <= slot_data_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            pend_ch_q    <= pend_ch_d;
            pend_op_q    <= pend_op_d;
            pend_bcast_q <= pend_bcast_d;
            pend_mask_q  <= pend_mask_d;
            pend_data_q  <= pend_data_d;
            bcnt_q       <= bcnt_d;
        end
    end

    // Slot storage, written only at the current slot on a commit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clk_en && hit_c) begin
            mem_q[cur_slot_c] <= merged_c;
        end
    end

    assign cur_ch    = cur_ch_q;
    assign cur_op    = cur_op_q;
    assign zero      = zero_q;
    assign slot_data = slot_data_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_jt12_slotreg.sv
// Directed bench for jt12_slotreg with CH=6, OPS=4, W=16.
module tb_jt12_slotreg;

    localparam int CH  = 6;
    localparam int OPS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic [1:0]  wr_op = '0;
    logic        wr_bcast = 1'b0;
    logic [15:0] wr_mask = '0;
    logic [15:0] wr_data = '0;
    logic        busy;
    logic        ovf;
    logic [2:0]  cur_ch;
    logic [1:0]  cur_op;
    logic        zero;
    logic [15:0] slot_data;

    int total = 0;
    int bad   = 0;

    // Bench-side slot cursor and expected storage contents
    int          t_ch = 0;
    int          t_op = 0;
    logic [15:0] exp_mem [CH*OPS];

    jt12_slotreg dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .wr        (wr),
        .wr_ch     (wr_ch),
        .wr_op     (wr_op),
        .wr_bcast  (wr_bcast),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .busy      (busy),
        .ovf       (ovf),
        .cur_ch    (cur_ch),
        .cur_op    (cur_op),
        .zero      (zero),
        .slot_data (slot_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clk_en cycle; inputs change and outputs are sampled at negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (t_ch == CH - 1) begin
            t_ch = 0;
            t_op = (t_op == OPS - 1) ? 0 : t_op + 1;
        end else begin
            t_ch = t_ch + 1;
        end
    endtask

    task automatic goto_slot(input int op, input int ch);
        for (int n = 0; n < 30 && !(t_op == op && t_ch == ch); n++) begin
            step();
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Walk one full period, checking cursor, zero flag and every word
    task automatic check_all(input string tag);
        for (int k = 0; k < CH*OPS; k++) begin
            chk({tag, "_ch"},   32'(cur_ch), 32'(t_ch));
            chk({tag, "_op"},   32'(cur_op), 32'(t_op));
            chk({tag, "_zero"}, 32'(zero), 32'((t_ch == 0 && t_op == 0) ? 1 : 0));
            chk({tag, "_data"}, 32'(slot_data), 32'(exp_mem[t_op*CH + t_ch]));
            step();
        end
    endtask

    task automatic issue(input int ch, input int op, input logic bc,
                         input logic [15:0] mask, input logic [15:0] data);
        wr       = 1'b1;
        wr_ch    = 3'(ch);
        wr_op    = 2'(op);
        wr_bcast = bc;
        wr_mask  = mask;
        wr_data  = data;
        step();
        wr       = 1'b0;
        wr_bcast = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < CH*OPS; i++) exp_mem[i] = 16'h0000;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ch",   32'(cur_ch), 32'd0);
        chk("rst_op",   32'(cur_op), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf",  32'(ovf), 32'd0);
        chk("rst_data", 32'(slot_data), 32'd0);
        rst    = 1'b0;
        clk_en = 1'b1;

        // 30 cycles of sequencing from (0,0); zero at cycles 0 and 24 only
        for (int k = 0; k < 30; k++) begin
            chk("seq_ch",   32'(cur_ch), 32'(k % 6));
            chk("seq_op",   32'(cur_op), 32'((k / 6) % 4));
            chk("seq_zero", 32'(zero), 32'((k == 0 || k == 24) ? 1 : 0));
            chk("seq_data", 32'(slot_data), 32'd0);
            step();
        end

        // Full write to (2,3) accepted at (0,1)
        goto_slot(0, 1);
        issue(3, 2, 1'b0, 16'hFFFF, 16'hA5A5);
        chk("w1_busy", 32'(busy), 32'd1);
        chk("w1_ovf",  32'(ovf), 32'd0);
        wait_idle(40, n);
        chk("w1_lat",  32'(n), 32'd14);
        chk("w1_ch",   32'(cur_ch), 32'd4);
        chk("w1_op",   32'(cur_op), 32'd2);
        exp_mem[2*CH + 3] = 16'hA5A5;
        check_all("w1");

        // Partial mask write over A5A5
        goto_slot(0, 0);
        issue(3, 2, 1'b0, 16'h00FF, 16'h1234);
        wait_idle(40, n);
        exp_mem[2*CH + 3] = 16'hA534;
        check_all("w2");

        // Broadcast op1 accepted at (1,3); wraps to finish on (1,3)
        goto_slot(1, 3);
        issue(5, 1, 1'b1, 16'hFFFF, 16'h00FF);
        chk("bc_busy", 32'(busy), 32'd1);
        wait_idle(40, n);
        chk("bc_lat", 32'(n), 32'd24);
        chk("bc_ch",  32'(cur_ch), 32'd4);
        chk("bc_op",  32'(cur_op), 32'd1);
        for (int c = 0; c < CH; c++) exp_mem[1*CH + c] = 16'h00FF;
        check_all("bc");

        // Zero mask: occupies its slot, clears busy, changes nothing
        goto_slot(0, 0);
        issue(1, 1, 1'b0, 16'h0000, 16'hFFFF);
        chk("m0_busy", 32'(busy), 32'd1);
        wait_idle(40, n);
        check_all("m0");

        // Drop while busy, then an out-of-range channel
        goto_slot(0, 0);
        issue(0, 3, 1'b0, 16'hF0F0, 16'hBEEF);
        chk("ov_busy0", 32'(busy), 32'd1);
        chk("ov_ovf0",  32'(ovf), 32'd0);
        issue(1, 0, 1'b0, 16'hFFFF, 16'h1111);
        chk("ov_ovf1",  32'(ovf), 32'd1);
        chk("ov_busy1", 32'(busy), 32'd1);
        step();
        chk("ov_ovf1c", 32'(ovf), 32'd0);
        wait_idle(40, n);
        exp_mem[3*CH + 0] = 16'hB0E0;
        issue(7, 0, 1'b0, 16'hFFFF, 16'h2222);
        chk("ov_ovf2",  32'(ovf), 32'd1);
        chk("ov_busy2", 32'(busy), 32'd0);
        step();
        chk("ov_ovf2c", 32'(ovf), 32'd0);
        check_all("ov");

        // clk_en low: everything holds, requests ignored
        wr = 1'b1; wr_ch = 3'd0; wr_op = 2'd0; wr_mask = 16'hFFFF; wr_data = 16'h5555;
        clk_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("hold_ch",   32'(cur_ch), 32'(t_ch));
        chk("hold_op",   32'(cur_op), 32'(t_op));
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_ovf",  32'(ovf), 32'd0);
        chk("hold_data", 32'(slot_data), 32'(exp_mem[t_op*CH + t_ch]));
        wr = 1'b0;
        clk_en = 1'b1;
        check_all("hold");

        // Reset between accept and commit
        goto_slot(0, 0);
        issue(4, 3, 1'b0, 16'hFFFF, 16'hFFFF);
        chk("mr_busy0", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ch",   32'(cur_ch), 32'd0);
        chk("mr_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        t_ch = 0;
        t_op = 0;
        for (int i = 0; i < CH*OPS; i++) exp_mem[i] = 16'h0000;
        check_all("mr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute runtime bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got=running expected=done");
        $fatal(1, "timeout");
    end

endmodule
